// File: rtl/apb_sys_pkg.sv
// Shared definitions for both ends of the command FIFO: the command encoding and
// the dispatcher state enum.
package apb_sys_pkg;

   localparam logic [1:0] CMD_NOP   = 2'b00;
   localparam logic [1:0] CMD_READ  = 2'b01;
   localparam logic [1:0] CMD_WRITE = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      SETUP,
      ACCESS
   } disp_state_t;

   function automatic logic is_xfer_cmd(input logic [1:0] cmd);
      return (cmd == CMD_READ) || (cmd == CMD_WRITE);
   endfunction

endpackage

// File: rtl/apb_cmd_dispatcher_if.sv
// APB bus bundle between the command dispatcher (master) and a peripheral (slave).
interface apb_cmd_dispatcher_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic              pready;
   logic [DATA_W-1:0] prdata;
   logic              pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output pready, prdata, pslverr
   );
endinterface

// File: rtl/apb_timeout_ctr.sv
// ACCESS-phase wait counter for the dispatcher; only instantiated when
// APB_TIMEOUT_EN is defined. expire flags the last permitted stalled cycle.
module apb_timeout_ctr #(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic load,
   input  logic count,
   output logic expire
);
   localparam int W = $clog2(TIMEOUT_CYC + 1);

   logic [W-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (!reset_n || load) begin
         cnt_reg <= '0;
      end else if (count) begin
         cnt_reg <= cnt_reg + W'(1);
      end
   end

   assign expire = count && (cnt_reg == W'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/apb_cmd_dispatcher.sv
// Pops NOP/READ/WRITE commands from the arbiter FIFO and runs each READ/WRITE as one
// APB transfer. Optional ACCESS-phase abort is enabled by defining APB_TIMEOUT_EN.
module apb_cmd_dispatcher
   import apb_sys_pkg::*;
#(
   parameter int                ADDR_W      = 32,
   parameter int                DATA_W      = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
   parameter int                ADDR_STEP   = 4,
   parameter int                TIMEOUT_CYC = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 fifo_empty,
   output logic                 fifo_rd_en,
   input  logic [1:0]           fifo_data,
   apb_cmd_dispatcher_if.master apb,
   output logic [DATA_W-1:0]    rd_data,
   output logic                 rd_valid,
   output logic                 done,
   output logic                 err,
   output logic                 busy
);

   disp_state_t       state_reg, state_next;
   logic              fetch_vld_reg, fetch_vld_next;
   logic              fifo_rd_en_reg, fifo_rd_en_next;
   logic              psel_reg, psel_next;
   logic              penable_reg, penable_next;
   logic              pwrite_reg, pwrite_next;
   logic [ADDR_W-1:0] paddr_reg, paddr_next;
   logic [DATA_W-1:0] pwdata_reg, pwdata_next;
   logic [DATA_W-1:0] rd_data_reg, rd_data_next;
   logic              rd_valid_reg, rd_valid_next;
   logic              done_reg, done_next;
   logic              err_reg, err_next;
   logic              busy_reg, busy_next;
   logic [ADDR_W-1:0] addr_ptr_reg, addr_ptr_next;
   logic [DATA_W-1:0] wr_cnt_reg, wr_cnt_next;
   logic              tmo_expire;

`ifdef APB_TIMEOUT_EN
   apb_timeout_ctr #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout_ctr (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (state_reg == SETUP),
      .count   ((state_reg == ACCESS) && !apb.pready),
      .expire  (tmo_expire)
   );
`else
   assign tmo_expire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         fetch_vld_reg  <= 1'b0;
         fifo_rd_en_reg <= 1'b0;
         psel_reg       <= 1'b0;
         penable_reg    <= 1'b0;
         pwrite_reg     <= 1'b0;
         paddr_reg      <= BASE_ADDR;
         pwdata_reg     <= '0;
         rd_data_reg    <= '0;
         rd_valid_reg   <= 1'b0;
         done_reg       <= 1'b0;
         err_reg        <= 1'b0;
         busy_reg       <= 1'b0;
         addr_ptr_reg   <= BASE_ADDR;
         wr_cnt_reg     <= '0;
      end else begin
         state_reg      <= state_next;
         fetch_vld_reg  <= fetch_vld_next;
         fifo_rd_en_reg <= fifo_rd_en_next;
         psel_reg       <= psel_next;
         penable_reg    <= penable_next;
         pwrite_reg     <= pwrite_next;
         paddr_reg      <= paddr_next;
         pwdata_reg     <= pwdata_next;
         rd_data_reg    <= rd_data_next;
         rd_valid_reg   <= rd_valid_next;
         done_reg       <= done_next;
         err_reg        <= err_next;
         busy_reg       <= busy_next;
         addr_ptr_reg   <= addr_ptr_next;
         wr_cnt_reg     <= wr_cnt_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      // The FIFO presents data the cycle after the pop strobe, so FETCH waits one cycle.
      fetch_vld_next  = fifo_rd_en_reg;
      fifo_rd_en_next = 1'b0;
      psel_next       = psel_reg;
      penable_next    = penable_reg;
      pwrite_next     = pwrite_reg;
      paddr_next      = paddr_reg;
      pwdata_next     = pwdata_reg;
      rd_data_next    = rd_data_reg;
      rd_valid_next   = 1'b0;
      done_next       = 1'b0;
      err_next        = 1'b0;
      addr_ptr_next   = addr_ptr_reg;
      wr_cnt_next     = wr_cnt_reg;

      case (state_reg)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_rd_en_next = 1'b1;
               state_next      = FETCH;
            end
         end
         FETCH: begin
            if (fetch_vld_reg) begin
               if (is_xfer_cmd(fifo_data)) begin
                  psel_next    = 1'b1;
                  penable_next = 1'b0;
                  pwrite_next  = (fifo_data == CMD_WRITE);
                  paddr_next   = addr_ptr_reg;
                  if (fifo_data == CMD_WRITE) begin
                     pwdata_next = wr_cnt_reg;
                  end
                  state_next   = SETUP;
               end else begin
                  err_next   = (fifo_data != CMD_NOP);
                  state_next = IDLE;
               end
            end
         end
         SETUP: begin
            penable_next = 1'b1;
            state_next   = ACCESS;
         end
         ACCESS: begin
            if (apb.pready) begin
               psel_next     = 1'b0;
               penable_next  = 1'b0;
               done_next     = 1'b1;
               err_next      = apb.pslverr;
               if (pwrite_reg) begin
                  wr_cnt_next = wr_cnt_reg + DATA_W'(1);
               end else begin
                  rd_data_next  = apb.prdata;
                  rd_valid_next = 1'b1;
               end
               addr_ptr_next = addr_ptr_reg + ADDR_W'(ADDR_STEP);
               state_next    = IDLE;
            end else if (tmo_expire) begin
               // Abort still consumes the address slot so later commands stay aligned.
               psel_next     = 1'b0;
               penable_next  = 1'b0;
               err_next      = 1'b1;
               addr_ptr_next = addr_ptr_reg + ADDR_W'(ADDR_STEP);
               state_next    = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase

      busy_next = (state_next != IDLE);
   end

   assign fifo_rd_en  = fifo_rd_en_reg;
   assign apb.psel    = psel_reg;
   assign apb.penable = penable_reg;
   assign apb.pwrite  = pwrite_reg;
   assign apb.paddr   = paddr_reg;
   assign apb.pwdata  = pwdata_reg;
   assign rd_data     = rd_data_reg;
   assign rd_valid    = rd_valid_reg;
   assign done        = done_reg;
   assign err         = err_reg;
   assign busy        = busy_reg;

endmodule

// File: tb/tb_apb_cmd_dispatcher.sv
// Self-checking bench for apb_cmd_dispatcher: FIFO and APB slave models plus a
// transaction-level reference model of pointer/counter behaviour.
module tb_apb_cmd_dispatcher;
   import apb_sys_pkg::*;

   localparam int          ADDR_W      = 32;
   localparam int          DATA_W      = 32;
   localparam logic [31:0] BASE_ADDR   = 32'h0000_0000;
   localparam int          ADDR_STEP   = 4;
   localparam int          TIMEOUT_CYC = 16;
`ifdef APB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif
   localparam int EV_XFER = 0;
   localparam int EV_ERR  = 1;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic        wr;
      logic [31:0] data;
      logic        er;
      logic        rv;
      int          acc;
   } ev_t;

   typedef struct {
      int          ws;
      logic        slverr;
      logic [31:0] rdata;
   } resp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic [1:0]  fifo_data;
   logic [31:0] rd_data;
   logic        rd_valid, done, err, busy;

   apb_cmd_dispatcher_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) apb ();

   apb_cmd_dispatcher #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .BASE_ADDR   (BASE_ADDR),
      .ADDR_STEP   (ADDR_STEP),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .fifo_data  (fifo_data),
      .apb        (apb.master),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .done       (done),
      .err        (err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   logic [1:0]  cmd_q[$];
   resp_t       resp_q[$];
   ev_t         log_q[$];
   ev_t         exp_q[$];
   logic [1:0]  scn_cmd[$];
   resp_t       scn_rsp[$];
   resp_t       cur;
   int          cyc, rden_cyc, acc;
   logic [31:0] s_addr, s_data;
   logic        s_wr;
   int          lat_err, stab_err, prot_err;
   int          checks, errors;
   logic [31:0] m_ptr, m_wcnt;

   // One clock: FIFO pop, monitor and slave response, all at posedge + 1.
   task automatic step();
      logic pop;
      ev_t  e;
      pop = fifo_rd_en;
      @(posedge clk);
      #1;
      cyc++;
      if (pop === 1'b1) begin
         if (cmd_q.size() == 0) prot_err++;
         else fifo_data = cmd_q.pop_front();
      end
      fifo_empty = (cmd_q.size() == 0);
      if (fifo_rd_en === 1'b1) rden_cyc = cyc;
      if (apb.penable === 1'b1 && apb.psel !== 1'b1) prot_err++;
      if (apb.psel === 1'b1 && busy !== 1'b1) prot_err++;
      if (rd_valid === 1'b1 && done !== 1'b1) prot_err++;
      if (done === 1'b1 || err === 1'b1) begin
         e.kind = (done === 1'b1) ? EV_XFER : EV_ERR;
         e.addr = s_addr;
         e.wr   = s_wr;
         e.data = s_wr ? s_data : rd_data;
         e.er   = err;
         e.rv   = rd_valid;
         e.acc  = acc;
         log_q.push_back(e);
         acc = 0;
      end
      if (apb.psel === 1'b1 && apb.penable === 1'b0) begin
         if (cyc - rden_cyc != 2) lat_err++;
         s_addr = apb.paddr;
         s_wr   = apb.pwrite;
         s_data = apb.pwdata;
         acc    = 0;
         if (resp_q.size() == 0) prot_err++;
         else cur = resp_q.pop_front();
      end
      if (apb.psel === 1'b1 && apb.penable === 1'b1) begin
         acc++;
         if (apb.paddr !== s_addr || apb.pwrite !== s_wr || apb.pwdata !== s_data) stab_err++;
         apb.pready  = (acc > cur.ws);
         apb.pslverr = apb.pready ? cur.slverr : 1'b0;
         apb.prdata  = cur.rdata;
      end else begin
         apb.pready  = 1'b0;
         apb.pslverr = 1'b0;
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      cmd_q.delete();
      resp_q.delete();
      log_q.delete();
      fifo_empty = 1'b1;
      acc    = 0;
      m_ptr  = BASE_ADDR;
      m_wcnt = 32'h0;
      step();
   endtask

   // Predicts the event stream from the command list, runs it, and scores it.
   task automatic run_scenario(input string name);
      ev_t   e;
      resp_t r;
      int    ri, idle_cnt, n;
      bit    fin;
      exp_q.delete();
      log_q.delete();
      lat_err = 0; stab_err = 0; prot_err = 0; ri = 0;
      foreach (scn_cmd[i]) begin
         if (scn_cmd[i] == CMD_READ || scn_cmd[i] == CMD_WRITE) begin
            r = scn_rsp[ri];
            ri++;
            e.wr   = (scn_cmd[i] == CMD_WRITE);
            e.addr = m_ptr;
            if (TMO_EN && r.ws >= TIMEOUT_CYC) begin
               e.kind = EV_ERR; e.data = 32'h0; e.er = 1'b1; e.rv = 1'b0; e.acc = TIMEOUT_CYC;
            end else begin
               e.kind = EV_XFER;
               e.data = e.wr ? m_wcnt : r.rdata;
               e.er   = r.slverr;
               e.rv   = !e.wr;
               e.acc  = r.ws + 1;
               if (e.wr) m_wcnt = m_wcnt + 32'd1;
            end
            m_ptr = m_ptr + ADDR_STEP;
            exp_q.push_back(e);
            resp_q.push_back(r);
         end else if (scn_cmd[i] == 2'b11) begin
            e.kind = EV_ERR; e.addr = 32'h0; e.wr = 1'b0; e.data = 32'h0;
            e.er = 1'b1; e.rv = 1'b0; e.acc = -1;
            exp_q.push_back(e);
         end
         cmd_q.push_back(scn_cmd[i]);
      end
      fifo_empty = (cmd_q.size() == 0);
      fin = 1'b0;
      idle_cnt = 0;
      for (int c = 0; c < 4000 && !fin; c++) begin
         step();
         if (cmd_q.size() == 0 && fifo_rd_en === 1'b0 && busy === 1'b0) idle_cnt++;
         else idle_cnt = 0;
         if (idle_cnt >= 2) fin = 1'b1;
      end
      checks++;
      if (fin !== 1'b1) begin
         errors++;
         $display("FAIL %s_complete: still busy after cycle budget, required idle", name);
      end
      checks++;
      if (log_q.size() !== exp_q.size()) begin
         errors++;
         $display("FAIL %s_event_count: got %0d required %0d", name, log_q.size(), exp_q.size());
      end
      n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (log_q[i].kind !== exp_q[i].kind || log_q[i].er !== exp_q[i].er || log_q[i].rv !== exp_q[i].rv) begin
            errors++;
            $display("FAIL %s_ev%0d_flags: got kind=%0d err=%b rv=%b required kind=%0d err=%b rv=%b", name, i,
                     log_q[i].kind, log_q[i].er, log_q[i].rv, exp_q[i].kind, exp_q[i].er, exp_q[i].rv);
         end
         if (exp_q[i].kind == EV_XFER) begin
            checks++;
            if (log_q[i].addr !== exp_q[i].addr || log_q[i].wr !== exp_q[i].wr || log_q[i].data !== exp_q[i].data) begin
               errors++;
               $display("FAIL %s_ev%0d_xfer: got addr=%h wr=%b data=%h required addr=%h wr=%b data=%h", name, i,
                        log_q[i].addr, log_q[i].wr, log_q[i].data, exp_q[i].addr, exp_q[i].wr, exp_q[i].data);
            end
         end
         if (exp_q[i].acc >= 0) begin
            checks++;
            if (log_q[i].acc !== exp_q[i].acc) begin
               errors++;
               $display("FAIL %s_ev%0d_access_cycles: got %0d required %0d", name, i, log_q[i].acc, exp_q[i].acc);
            end
         end
      end
      checks++;
      if (lat_err !== 0 || stab_err !== 0 || prot_err !== 0) begin
         errors++;
         $display("FAIL %s_protocol: got latency=%0d stability=%0d protocol=%0d violations, required 0", name,
                  lat_err, stab_err, prot_err);
      end
      scn_cmd.delete();
      scn_rsp.delete();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) step();
      checks++;
      if ({apb.psel, apb.penable, apb.pwrite, fifo_rd_en, rd_valid, done, err, busy} !== 8'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b required 00000000",
                  {apb.psel, apb.penable, apb.pwrite, fifo_rd_en, rd_valid, done, err, busy});
      end
      checks++;
      if (apb.paddr !== BASE_ADDR) begin
         errors++;
         $display("FAIL reset_paddr: got %h required %h", apb.paddr, BASE_ADDR);
      end
      checks++;
      if (apb.pwdata !== 32'h0 || rd_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: got pwdata=%h rd_data=%h required 0", apb.pwdata, rd_data);
      end
      reset_n = 1'b1;
      m_ptr = BASE_ADDR;
      m_wcnt = 32'h0;
      step();
      $display("reset: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_single_write();
      do_reset();
      scn_cmd = '{CMD_WRITE, CMD_WRITE};
      scn_rsp = '{'{0, 1'b0, 32'h0}, '{0, 1'b0, 32'h0}};
      run_scenario("single_write");
      checks++;
      if (log_q.size() != 2 || log_q[0].addr !== 32'h0 || log_q[0].data !== 32'h0 ||
          log_q[1].addr !== 32'h4 || log_q[1].data !== 32'h1) begin
         errors++;
         $display("FAIL single_write_values: got %0d events, required addr/data 0/0 then 4/1", log_q.size());
      end
      $display("single_write: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_read_wait();
      do_reset();
      scn_cmd = '{CMD_READ};
      scn_rsp = '{'{3, 1'b0, 32'hDEAD_BEEF}};
      run_scenario("read_wait");
      checks++;
      if (log_q.size() != 1 || log_q[0].data !== 32'hDEAD_BEEF || log_q[0].rv !== 1'b1 || log_q[0].acc != 4) begin
         errors++;
         $display("FAIL read_wait_values: got %0d events, required rd_data=deadbeef rv=1 over 4 ACCESS cycles",
                  log_q.size());
      end
      $display("read_wait: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_nop_illegal();
      do_reset();
      scn_cmd = '{CMD_NOP, 2'b11, CMD_WRITE};
      scn_rsp = '{'{0, 1'b0, 32'h0}};
      run_scenario("nop_illegal");
      checks++;
      if (log_q.size() != 2 || log_q[0].kind != EV_ERR || log_q[1].kind != EV_XFER || log_q[1].addr !== 32'h0) begin
         errors++;
         $display("FAIL nop_illegal_values: got %0d events, required err-only then write at 0", log_q.size());
      end
      $display("nop_illegal: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_slave_error();
      do_reset();
      scn_cmd = '{CMD_WRITE, CMD_READ};
      scn_rsp = '{'{0, 1'b1, 32'h0}, '{1, 1'b0, 32'h1357_9BDF}};
      run_scenario("slave_error");
      checks++;
      if (log_q.size() != 2 || log_q[0].kind != EV_XFER || log_q[0].er !== 1'b1 || log_q[1].addr !== 32'h4) begin
         errors++;
         $display("FAIL slave_error_values: got %0d events, required err with done then next addr 4", log_q.size());
      end
      $display("slave_error: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_reset_mid_access();
      bit hit;
      do_reset();
      lat_err = 0; stab_err = 0; prot_err = 0;
      cmd_q.push_back(CMD_READ);
      resp_q.push_back('{100, 1'b0, 32'h1234_5678});
      fifo_empty = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 50 && !hit; c++) begin
         step();
         if (apb.psel === 1'b1 && apb.penable === 1'b1 && acc >= 2) hit = 1'b1;
      end
      checks++;
      if (hit !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_reach_access: ACCESS not reached, required within 50 cycles");
      end
      reset_n = 1'b0;
      step();
      checks++;
      if (apb.psel !== 1'b0 || apb.penable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_ctrl: got psel=%b penable=%b busy=%b done=%b required 0 0 0 0",
                  apb.psel, apb.penable, busy, done);
      end
      checks++;
      if (apb.paddr !== BASE_ADDR) begin
         errors++;
         $display("FAIL mid_reset_paddr: got %h required %h", apb.paddr, BASE_ADDR);
      end
      step();
      reset_n = 1'b1;
      step();
      step();
      checks++;
      if (log_q.size() != 0) begin
         errors++;
         $display("FAIL mid_reset_no_completion: got %0d events required 0", log_q.size());
      end
      resp_q.delete();
      acc = 0;
      m_ptr = BASE_ADDR;
      m_wcnt = 32'h0;
      scn_cmd = '{CMD_WRITE};
      scn_rsp = '{'{0, 1'b0, 32'h0}};
      run_scenario("after_mid_reset");
      $display("reset_mid_access: checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_random();
      logic [1:0] c;
      do_reset();
      for (int i = 0; i < 40; i++) begin
         c = 2'($urandom_range(0, 3));
         scn_cmd.push_back(c);
         if (c == CMD_READ || c == CMD_WRITE)
            scn_rsp.push_back('{int'($urandom_range(0, 4)), ($urandom_range(0, 7) == 0), 32'($urandom)});
      end
      run_scenario("random");
      $display("random: checks=%0d errors=%0d", checks, errors);
   endtask

`ifdef APB_TIMEOUT_EN
   task automatic test_timeout();
      do_reset();
      scn_cmd = '{CMD_READ, CMD_WRITE};
      scn_rsp = '{'{40, 1'b0, 32'hAAAA_5555}, '{0, 1'b0, 32'h0}};
      run_scenario("timeout");
      checks++;
      if (log_q.size() != 2 || log_q[0].kind != EV_ERR || log_q[0].acc != 16 || log_q[1].addr !== 32'h4) begin
         errors++;
         $display("FAIL timeout_values: got %0d events, required abort after 16 cycles then addr 4", log_q.size());
      end
      $display("timeout: checks=%0d errors=%0d", checks, errors);
   endtask
`endif

   initial begin
      reset_n = 1'b0;
      fifo_empty = 1'b1;
      fifo_data = 2'b00;
      apb.pready = 1'b0;
      apb.prdata = 32'h0;
      apb.pslverr = 1'b0;
      cyc = 0; rden_cyc = -100; acc = 0;
      s_addr = 32'h0; s_data = 32'h0; s_wr = 1'b0;
      cur = '{0, 1'b0, 32'h0};
      lat_err = 0; stab_err = 0; prot_err = 0;
      checks = 0; errors = 0;
      m_ptr = BASE_ADDR; m_wcnt = 32'h0;
      test_reset();
      test_single_write();
      test_read_wait();
      test_nop_illegal();
      test_slave_error();
      test_reset_mid_access();
      test_random();
`ifdef APB_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
